kf76489_host_write_sequencer: RTL
=================================

Name: kf76489_host_write_sequencer

Overview:
Host-side write master for the KF76489 sound core. It accepts one register-write request per valid/ready handshake and emits the chip's CE_N/WE_N/D byte protocol. Frequency registers produce a latch byte followed by a data byte; attenuation and noise registers produce a single latch byte. It sits between a CPU/sequencer bus and the KF76489 write port, and owns all strobe timing.

Parameters:
SETUP_CYCLES, 1, cycles with CE_N=0, WE_N=1 and D_OUT valid before WE_N falls; minimum 1.
WE_LOW_CYCLES, 2, cycles WE_N is held low; minimum 1.
HOLD_CYCLES, 1, cycles after WE_N rises with CE_N=0 and D_OUT unchanged; minimum 1.
GAP_CYCLES, 2, cycles with CE_N=1 between bytes and after the last byte; minimum 1.

Ports:
clock  in  1  single system clock; all logic on posedge.
reset_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  sequencer idle, so a request is accepted this cycle.
req_register  in  3  chip register code: 000 tone1 freq, 100 tone1 atten, 010 tone2 freq, 110 tone2 atten, 001 tone3 freq, 101 tone3 atten, 011 noise ctrl, 111 noise atten.
req_value  in  10  value; single-byte registers use [3:0] only.
busy  out  1  equals ~req_ready.
CE_N  out  1  chip enable to the sound core.
WE_N  out  1  write strobe to the sound core.
D_OUT  out  8  byte to the sound core D_IN.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, CE_N=1, WE_N=1, D_OUT=8'h00, req_ready=1 after release. Mid-operation reset aborts immediately, discards any pending byte, and raises CE_N and WE_N asynchronously.
- All outputs are registered. req_ready=1 only in IDLE. Accept when req_valid & req_ready (cycle N); req_register and req_value are captured at N. Inputs are ignored when not ready.
- Latch byte: D_OUT[0]=1; D_OUT[3:1]=req_register; D_OUT[4+i]=value[3-i] for i=0..3.
- Data byte (frequency codes 000/010/001 only): D_OUT[0]=0; D_OUT[1]=0; D_OUT[2+i]=value[9-i] for i=0..5.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> GAP, then:
  - if a data byte is pending: GAP -> SETUP with the data byte;
  - otherwise: GAP -> IDLE.
- Per state:
  - SETUP: CE_N=0, WE_N=1, D_OUT=byte.
  - STROBE: CE_N=0, WE_N=0.
  - HOLD: CE_N=0, WE_N=1.
  - GAP: CE_N=1, WE_N=1, D_OUT holds its last value.
  - Each state lasts its parameter's cycle count, using one shared down-counter sized for the largest parameter.
- Latency: CE_N falls at N+1. The first WE_N rise is at N+1+SETUP+WE_LOW.
  - A single-byte write returns req_ready=1 at N+1+S+W+H+G (N+7 with defaults).
  - A two-byte write returns req_ready=1 at N+1+2(S+W+H+G) (N+13 with defaults).
- D_OUT changes only on entry to SETUP, so it stays stable from SETUP through HOLD. The core registers D_IN and detects the WE_N rising edge one cycle late, so HOLD_CYCLES>=1 is mandatory.
- Back-to-back requests: req_valid held high is accepted on the IDLE cycle, so there is a minimum of one IDLE cycle between requests.

Optional Feature:
KF76489_READY_WAIT_EN:
- Defined: adds input port READY (1 bit). STROBE keeps WE_N=0 past WE_LOW_CYCLES until READY=1 is sampled, then proceeds to HOLD on the next cycle. READY=0 during reset has no effect.
- Undefined: there is no READY port and STROBE length is fixed at WE_LOW_CYCLES.

Test Plan:
- Reset release, no request -> req_ready=1, busy=0, CE_N=1, WE_N=1, D_OUT=8'h00 held for 20 cycles.
- Tone1 freq, value 10'h2A5 -> D_OUT=8'hA1 latch byte, then D_OUT=8'h54 data byte. Exactly two WE_N low pulses of 2 cycles each. req_ready returns at N+13.
- Tone2 atten, value 4'hF -> single byte 8'hFD with one WE_N pulse. req_ready returns at N+7. CE_N high during GAP.
- Noise ctrl, value 4'h4 -> single byte 8'h27. A second request held valid while busy is not accepted until req_ready=1, then issues with one IDLE cycle between.
- reset_n pulsed low during STROBE of the first byte of a freq write -> CE_N and WE_N go to 1 immediately, no data byte follows, req_ready=1 after release.
- With KF76489_READY_WAIT_EN, READY held low for 5 cycles during STROBE -> WE_N low for 6 cycles; timing otherwise unchanged.

Source files
------------

// File: rtl/kf76489_host_write_sequencer.sv
// Host write master for the KF76489 sound core: turns one register-write request into CE_N/WE_N/D byte writes.
// Latency: CE_N falls 1 cycle after accept; req_ready returns after S+W+H+G (1 byte) or 2*(S+W+H+G) (2 bytes) cycles.
// Backpressure: req_ready only in IDLE; optional KF76489_READY_WAIT_EN adds READY, which stretches WE_N low until sampled high.
module kf76489_host_write_sequencer #(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned WE_LOW_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1,
    parameter int unsigned GAP_CYCLES    = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_register,
    input  logic [9:0] req_value,
    output logic       busy,
    output logic       CE_N,
    output logic       WE_N,
    output logic [7:0] D_OUT
`ifdef KF76489_READY_WAIT_EN
    ,
    input  logic       READY
`endif
);

    // Sequencer states, one per phase of a single byte write.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;

    // One shared down-counter, wide enough for the longest phase.
    localparam int unsigned MAX_SW  = (SETUP_CYCLES > WE_LOW_CYCLES) ? SETUP_CYCLES : WE_LOW_CYCLES;
    localparam int unsigned MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_SW > MAX_HG) ? MAX_SW : MAX_HG;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Counter load values: a phase of N cycles counts N-1 down to 0.
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WE_LOW_LOAD = CNT_W'(WE_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Latch byte: bit0=1, register code in [3:1], value[3:0] bit-reversed into [7:4].
    function automatic logic [7:0] latch_byte(input logic [2:0] reg_code, input logic [9:0] value);
        return {value[0], value[1], value[2], value[3], reg_code, 1'b1};
    endfunction

    // Data byte: [1:0]=00, value[9:4] bit-reversed into [7:2].
    function automatic logic [7:0] data_byte(input logic [9:0] value);
        return {value[4], value[5], value[6], value[7], value[8], value[9], 2'b00};
    endfunction

    // Only the three tone frequency registers carry a second (data) byte.
    function automatic logic is_freq(input logic [2:0] reg_code);
        return (reg_code == 3'b000) || (reg_code == 3'b010) || (reg_code == 3'b001);
    endfunction

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             enter_setup;
    logic [7:0]       setup_byte;
    logic [7:0]       data_byte_q;
    logic             data_pend_q;
    logic             strobe_release;

`ifdef KF76489_READY_WAIT_EN
    // The core may hold off the end of the strobe; WE_N stays low until READY is seen high.
    assign strobe_release = READY;
`else
    assign strobe_release = 1'b1;
`endif

    // Next-state and phase counter; also picks the byte to present on entry to SETUP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enter_setup = 1'b0;
        setup_byte  = data_byte_q;
        case (state_q)
            ST_IDLE: begin
                // In IDLE req_ready is high, so req_valid alone is the accept.
                if (req_valid) begin
                    state_d     = ST_SETUP;
                    cnt_d       = SETUP_LOAD;
                    enter_setup = 1'b1;
                    setup_byte  = latch_byte(req_register, req_value);
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = WE_LOW_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    // Counter parks at zero while waiting for the release condition.
                    if (strobe_release) begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    if (data_pend_q) begin
                        state_d     = ST_SETUP;
                        cnt_d       = SETUP_LOAD;
                        enter_setup = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers; reset aborts any write in progress.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the data byte at accept; it is consumed when GAP loops back to SETUP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_byte_q <= 8'h00;
            data_pend_q <= 1'b0;
        end else if (state_q == ST_IDLE && req_valid) begin
            data_byte_q <= data_byte(req_value);
            data_pend_q <= is_freq(req_register);
        end else if (state_q == ST_GAP && enter_setup) begin
            data_pend_q <= 1'b0;
        end
    end

    // Registered pin outputs, decoded from the next state so they line up with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            CE_N      <= 1'b1;
            WE_N      <= 1'b1;
            D_OUT     <= 8'h00;
            req_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            CE_N      <= !((state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD));
            WE_N      <= (state_d != ST_STROBE);
            req_ready <= (state_d == ST_IDLE);
            busy      <= (state_d != ST_IDLE);
            // D_OUT only moves on SETUP entry, so it is stable through STROBE and HOLD.
            if (enter_setup) begin
                D_OUT <= setup_byte;
            end
        end
    end

endmodule
